// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL acquisition/lock controller.
// State encoding, default widths and the saturating magnitude helper.
package adpll_pkg;

   localparam int DEF_CTRL_WIDTH = 5;
   localparam int DEF_PDET_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_DECIDE  = 3'd3,
      ST_TRACK   = 3'd4,
      ST_LOCKED  = 3'd5
   } state_e;

   // Magnitude of a w-bit signed value held sign-extended in 32 bits;
   // the most-negative code saturates instead of wrapping.
   function automatic logic [31:0] sat_abs(
      input logic signed [31:0] x,
      input int                 w
   );
      logic signed [31:0] lo;
      lo = -(32'sd1 <<< (w - 1));
      if (x == lo) return (32'd1 << (w - 1)) - 32'd1;
      if (x < 0) return -x;
      return x;
   endfunction

endpackage

// File: rtl/adpll_lock_monitor.sv
// Lock/unlock qualifier: error magnitude compare plus consecutive-run
// counters that flag when a lock or loss-of-lock run completes.
module adpll_lock_monitor
   import adpll_pkg::*;
#(
   parameter int PDET_WIDTH   = DEF_PDET_WIDTH,
   parameter int LOCK_TOL     = 2,
   parameter int LOCK_COUNT   = 16,
   parameter int UNLOCK_TOL   = 8,
   parameter int UNLOCK_COUNT = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         clr_i,
   input  logic                         trk_en_i,
   input  logic                         lck_en_i,
   input  logic signed [PDET_WIDTH-1:0] error_i,
   output logic                         lock_hit_o,
   output logic                         unlock_hit_o
);

   localparam int RW = $clog2(LOCK_COUNT + 1);
   localparam int UW = $clog2(UNLOCK_COUNT + 1);

   logic [31:0]   mag;
   logic          in_tol;
   logic          out_tol;
   logic [RW-1:0] run_q, run_d;
   logic [UW-1:0] miss_q, miss_d;

   assign mag     = sat_abs(32'(error_i), PDET_WIDTH);
   assign in_tol  = (mag <= 32'(LOCK_TOL));
   assign out_tol = (mag > 32'(UNLOCK_TOL));

   assign lock_hit_o   = trk_en_i && in_tol &&
                         (run_q == RW'(LOCK_COUNT - 1));
   assign unlock_hit_o = lck_en_i && out_tol &&
                         (miss_q == UW'(UNLOCK_COUNT - 1));

   always_comb begin
      run_d  = run_q;
      miss_d = miss_q;
      if (clr_i) begin
         run_d  = '0;
         miss_d = '0;
      end else begin
         if (trk_en_i) run_d = in_tol ? run_q + RW'(1) : '0;
         if (lck_en_i) miss_d = out_tol ? miss_q + UW'(1) : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         run_q  <= '0;
         miss_q <= '0;
      end else begin
         run_q  <= run_d;
         miss_q <= miss_d;
      end
   end

endmodule

// File: rtl/adpll_lock_sequencer.sv
// ADPLL acquisition controller: SAR search of the DCO bias code, then
// closed-loop tracking with lock detection and loss-of-lock recalibration.
module adpll_lock_sequencer
   import adpll_pkg::*;
#(
   parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH,
   parameter int PDET_WIDTH     = DEF_PDET_WIDTH,
   parameter int SETTLE_SAMPLES = 4,
   parameter int MEAS_SAMPLES   = 8,
   parameter int LOCK_TOL       = 2,
   parameter int LOCK_COUNT     = 16,
   parameter int UNLOCK_TOL     = 8,
   parameter int UNLOCK_COUNT   = 4
) (
   input  logic                         fpga_clk_i,
   input  logic                         reset_n_i,
   input  logic                         enable_i,
   input  logic                         restart_i,
   input  logic                         err_valid_i,
   input  logic signed [PDET_WIDTH-1:0] error_i,
   output logic [CTRL_WIDTH-1:0]        bias_o,
   output logic                         loop_en_o,
   output logic                         cal_done_o,
   output logic                         locked_o,
   output logic                         lost_lock_o,
   output logic [2:0]                   state_o
);

   localparam int MW   = (MEAS_SAMPLES > 1) ? $clog2(MEAS_SAMPLES) : 0;
   localparam int AW   = PDET_WIDTH + MW;
   localparam int KW   = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;
   localparam int CMAX = (SETTLE_SAMPLES > MEAS_SAMPLES) ?
                         SETTLE_SAMPLES : MEAS_SAMPLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CTRL_WIDTH-1:0] BIAS_MID =
      CTRL_WIDTH'(1) << (CTRL_WIDTH - 1);
   localparam logic [KW-1:0] K_TOP = KW'(CTRL_WIDTH - 1);

   state_e                 state_q;
   logic [CTRL_WIDTH-1:0]  bias_q;
   logic [CTRL_WIDTH-1:0]  bias_dec;
   logic [KW-1:0]          k_q;
   logic [CW-1:0]          cnt_q;
   logic signed [AW-1:0]   acc_q;
   logic signed [AW-1:0]   err_ext;
   logic                   loop_en_q;
   logic                   cal_done_q;
   logic                   locked_q;
   logic                   lost_lock_q;

   logic trk_en, lck_en, mon_clr;
   logic lock_hit, unlock_hit;
   logic sar_start, lost_evt;

   assign err_ext = AW'(error_i);

   assign trk_en  = err_valid_i && (state_q == ST_TRACK);
   assign lck_en  = err_valid_i && (state_q == ST_LOCKED);
   assign mon_clr = !((state_q == ST_TRACK) || (state_q == ST_LOCKED));

   // Qualified only when enable_i is high; enable low overrides everything.
   assign lost_evt  = !restart_i && (state_q == ST_LOCKED) && unlock_hit;
   assign sar_start = (state_q == ST_IDLE) || restart_i || lost_evt;

   // Resolve the trial bit and arm the next lower one in a single step.
   always_comb begin
      bias_dec = bias_q;
      bias_dec[k_q] = ~acc_q[AW-1];
      if (k_q != '0) bias_dec[k_q - KW'(1)] = 1'b1;
   end

   adpll_lock_monitor #(
      .PDET_WIDTH   (PDET_WIDTH),
      .LOCK_TOL     (LOCK_TOL),
      .LOCK_COUNT   (LOCK_COUNT),
      .UNLOCK_TOL   (UNLOCK_TOL),
      .UNLOCK_COUNT (UNLOCK_COUNT)
   ) u_mon (
      .clk_i        (fpga_clk_i),
      .rst_n_i      (reset_n_i),
      .clr_i        (mon_clr),
      .trk_en_i     (trk_en),
      .lck_en_i     (lck_en),
      .error_i      (error_i),
      .lock_hit_o   (lock_hit),
      .unlock_hit_o (unlock_hit)
   );

   always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         bias_q      <= BIAS_MID;
         k_q         <= K_TOP;
         cnt_q       <= '0;
         acc_q       <= '0;
         loop_en_q   <= 1'b0;
         cal_done_q  <= 1'b0;
         locked_q    <= 1'b0;
         lost_lock_q <= 1'b0;
      end else begin
         lost_lock_q <= 1'b0;
         if (!enable_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            loop_en_q  <= 1'b0;
            cal_done_q <= 1'b0;
            locked_q   <= 1'b0;
         end else if (sar_start) begin
            state_q     <= ST_SETTLE;
            bias_q      <= BIAS_MID;
            k_q         <= K_TOP;
            cnt_q       <= '0;
            acc_q       <= '0;
            loop_en_q   <= 1'b0;
            cal_done_q  <= 1'b0;
            locked_q    <= 1'b0;
            lost_lock_q <= lost_evt;
         end else begin
            unique case (state_q)
               ST_SETTLE: begin
                  if (err_valid_i) begin
                     if (cnt_q == CW'(SETTLE_SAMPLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_MEASURE;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end
               end
               ST_MEASURE: begin
                  if (err_valid_i) begin
                     acc_q <= acc_q + err_ext;
                     if (cnt_q == CW'(MEAS_SAMPLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_DECIDE;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end
               end
               ST_DECIDE: begin
                  bias_q <= bias_dec;
                  acc_q  <= '0;
                  if (k_q != '0) begin
                     k_q     <= k_q - KW'(1);
                     state_q <= ST_SETTLE;
                  end else begin
                     state_q    <= ST_TRACK;
                     loop_en_q  <= 1'b1;
                     cal_done_q <= 1'b1;
                  end
               end
               ST_TRACK: begin
                  if (lock_hit) begin
                     state_q  <= ST_LOCKED;
                     locked_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bias_o      = bias_q;
   assign loop_en_o   = loop_en_q;
   assign cal_done_o  = cal_done_q;
   assign locked_o    = locked_q;
   assign lost_lock_o = lost_lock_q;
   assign state_o     = state_q;

endmodule
